trap_ctrl: RTL

- Trap/return sequencer sitting directly upstream of the CSR register file in the pipeline core.
- Watches the commit-stage instruction, raw interrupt lines and CSR enable bits.
- Decides when to take an interrupt, exception or mret, and pulses the CSR file's irq_src/exp_src/mret_ena inputs with the PC and cause to record.
- Then flushes the pipeline and redirects fetch to the trap vector or mepc returned by the CSR file.

---
 rtl/trap_ctrl_pkg.sv | 26 ++
 rtl/trap_ctrl_irq_sync.sv | 25 ++
 rtl/trap_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap/return sequencer: cause codes,
// sequencer state encoding and the interrupt-bit position helper.
package trap_ctrl_pkg;

   // Interrupt cause codes (low bits of mcause)
   localparam logic [3:0] CAUSE_MEI = 4'd11;
   localparam logic [3:0] CAUSE_MSI = 4'd3;
   localparam logic [3:0] CAUSE_MTI = 4'd7;

   // Depth of the external interrupt synchroniser
   localparam int SYNC_DEPTH = 2;

   // Sequencer states
   typedef enum logic [1:0] {
      TRAP_IDLE  = 2'd0,
      TRAP_ENTER = 2'd1,
      TRAP_JUMP  = 2'd2,
      TRAP_MRET  = 2'd3
   } trap_state_e;

   // Position of the interrupt flag in mcause for a given data width
   function automatic int int_bit(input int xlen);
      return xlen - 1;
   endfunction

endpackage

// File: rtl/trap_ctrl_irq_sync.sv
// Level synchroniser for an asynchronous interrupt line.
// Output follows the input after DEPTH clock edges.
module irq_sync #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_sync
);

   logic [DEPTH-1:0] r_sync;

   // Shift the raw level through the synchroniser chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[DEPTH-2:0], i_async};
      end
   end

   assign o_sync = r_sync[DEPTH-1];

endmodule

// File: rtl/trap_ctrl.sv
// Trap/return sequencer: detects exceptions, interrupts and mret at
// commit, pulses the CSR file, then flushes and redirects fetch.
module trap_ctrl
   import trap_ctrl_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int XLEN   = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ext_irq_i,
   input  logic              sft_irq_i,
   input  logic              tmr_irq_i,
   input  logic              meie_i,
   input  logic              msie_i,
   input  logic              mtie_i,
   input  logic              glb_irq_i,
   input  logic              cmt_valid_i,
   input  logic [ADDR_W-1:0] cmt_pc_i,
   input  logic              exp_req_i,
   input  logic [3:0]        exp_code_i,
   input  logic [XLEN-1:0]   exp_tval_i,
   input  logic              mret_i,
   input  logic              mem_busy_i,
   input  logic [ADDR_W-1:0] irq_pc_i,
   input  logic [ADDR_W-1:0] mepc_i,
   output logic              irq_src_o,
   output logic              exp_src_o,
   output logic [ADDR_W-1:0] trap_pc_o,
   output logic [XLEN-1:0]   mcause_o,
   output logic [XLEN-1:0]   mtval_o,
   output logic              mret_ena_o,
   output logic              stall_o,
   output logic              flush_o,
   output logic              jump_ena_o,
   output logic [ADDR_W-1:0] jump_pc_o
);

   localparam int INT_BIT = int_bit(XLEN);

   trap_state_e       r_state;
   trap_state_e       w_state_next;
   logic [ADDR_W-1:0] r_pc;
   logic [XLEN-1:0]   r_cause;
   logic [XLEN-1:0]   r_tval;
   logic              r_is_irq;

   logic              w_ext_s;
   logic              w_ext_p;
   logic              w_sft_p;
   logic              w_tmr_p;
   logic              w_irq_pend;
   logic [3:0]        w_irq_code;
   logic              w_idle_ok;
   logic              w_det_exp;
   logic              w_det_irq;
   logic              w_det_mret;

   irq_sync #(
      .DEPTH (SYNC_DEPTH)
   ) u_irq_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (ext_irq_i),
      .o_sync  (w_ext_s)
   );

   assign w_ext_p    = w_ext_s & meie_i;
   assign w_sft_p    = sft_irq_i & msie_i;
   assign w_tmr_p    = tmr_irq_i & mtie_i;
   assign w_irq_pend = glb_irq_i & (w_ext_p | w_sft_p | w_tmr_p);
   assign w_irq_code = w_ext_p ? CAUSE_MEI : (w_sft_p ? CAUSE_MSI : CAUSE_MTI);

   // Detection is gated by rst_n so nothing is requested while reset is held
   assign w_idle_ok  = rst_n & cmt_valid_i & (r_state == TRAP_IDLE);
   assign w_det_exp  = w_idle_ok & exp_req_i;
   assign w_det_irq  = w_idle_ok & ~exp_req_i & w_irq_pend & ~mem_busy_i;
   assign w_det_mret = w_idle_ok & ~exp_req_i & ~(w_irq_pend & ~mem_busy_i) & mret_i;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= TRAP_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Latch pc/cause/tval on trap detection; held until the next detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc     <= '0;
         r_cause  <= '0;
         r_tval   <= '0;
         r_is_irq <= 1'b0;
      end else if (w_det_exp) begin
         r_pc     <= cmt_pc_i;
         r_cause  <= XLEN'(exp_code_i);
         r_tval   <= exp_tval_i;
         r_is_irq <= 1'b0;
      end else if (w_det_irq) begin
         r_pc             <= cmt_pc_i;
         r_cause          <= XLEN'(w_irq_code);
         r_cause[INT_BIT] <= 1'b1;
         r_tval           <= '0;
         r_is_irq         <= 1'b1;
      end
   end

   // Next-state and output decode
   always_comb begin
      w_state_next = r_state;
      irq_src_o    = 1'b0;
      exp_src_o    = 1'b0;
      trap_pc_o    = '0;
      mcause_o     = '0;
      mtval_o      = '0;
      mret_ena_o   = 1'b0;
      stall_o      = 1'b0;
      flush_o      = 1'b0;
      jump_ena_o   = 1'b0;
      jump_pc_o    = '0;
      case (r_state)
         TRAP_IDLE: begin
            if (w_det_exp || w_det_irq) begin
               stall_o      = 1'b1;
               w_state_next = TRAP_ENTER;
            end else if (w_det_mret) begin
               stall_o      = 1'b1;
               w_state_next = TRAP_MRET;
            end
         end
         TRAP_ENTER: begin
            irq_src_o    = r_is_irq;
            exp_src_o    = ~r_is_irq;
            trap_pc_o    = r_pc;
            mcause_o     = r_cause;
            mtval_o      = r_tval;
            stall_o      = 1'b1;
            w_state_next = TRAP_JUMP;
         end
         TRAP_JUMP: begin
            flush_o      = 1'b1;
            jump_ena_o   = 1'b1;
            stall_o      = 1'b1;
            jump_pc_o    = irq_pc_i;
            w_state_next = TRAP_IDLE;
         end
         TRAP_MRET: begin
            mret_ena_o   = 1'b1;
            flush_o      = 1'b1;
            jump_ena_o   = 1'b1;
            stall_o      = 1'b1;
            jump_pc_o    = mepc_i;
            w_state_next = TRAP_IDLE;
         end
         default: w_state_next = TRAP_IDLE;
      endcase
   end

endmodule
